// File: rtl/tf_pkg.sv
// Shared types, constants and the coin-value decode for the ticket-machine coin accumulator.
package tf_pkg;

  localparam int unsigned MONEY_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COLLECT    = 3'd1,
    SEND_RDY   = 3'd2,
    SEND_FEE   = 3'd3,
    SEND_MONEY = 3'd4,
    WAIT_CMP   = 3'd5
  } tf_state_e;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
    logic [MONEY_W-1:0] val;
    unique case (code)
      COIN_1:  val = MONEY_W'(1);
      COIN_2:  val = MONEY_W'(2);
      COIN_5:  val = MONEY_W'(5);
      COIN_10: val = MONEY_W'(10);
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tf_coin_dec.sv
// Combinational decode of a 2-bit coin code into its Taka value.
module tf_coin_dec
  import tf_pkg::*;
(
  input  logic [1:0]         i_coin_code,
  output logic [MONEY_W-1:0] o_value
);

  assign o_value = coin_value(i_coin_code);

endmodule

// File: rtl/tf_coin_acc.sv
// Coin accumulator: latches the fee, collects coins until paid/cancel/timeout, then
// emits the ready/fee/money burst to the subtractor and waits for its completion pulse.
module tf_coin_acc
  import tf_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_RDY4,
  input  logic [MONEY_W-1:0] fee_in,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic               cancel,
  input  logic               state_cmp5,
  output logic               out_RDY4,
  output logic [MONEY_W-1:0] DATA_out4,
  output logic               coin_rej,
  output logic               busy,
  output logic               state_cmp4
);

  tf_state_e          r_state, w_state_nxt;
  logic [MONEY_W-1:0] r_fee, w_fee_nxt;
  logic [MONEY_W-1:0] r_money, w_money_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic               r_refund, w_refund_nxt;

  logic               r_out_rdy, w_out_rdy_nxt;
  logic [MONEY_W-1:0] r_data, w_data_nxt;
  logic               r_coin_rej, w_coin_rej_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_cmp4, w_cmp4_nxt;

  logic [MONEY_W-1:0] w_coin_val;
  logic [MONEY_W:0]   w_sum;
  logic               w_accept;
  logic               w_timeout;

  tf_coin_dec u_coin_dec (
    .i_coin_code (coin_code),
    .o_value     (w_coin_val)
  );

  // One extra bit so an overflowing coin can be detected and returned.
  assign w_sum     = {1'b0, r_money} + {1'b0, w_coin_val};
  assign w_accept  = coin_valid && !w_sum[MONEY_W];
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_fee_nxt      = r_fee;
    w_money_nxt    = r_money;
    w_timer_nxt    = r_timer;
    w_refund_nxt   = r_refund;
    w_out_rdy_nxt  = 1'b0;
    w_data_nxt     = r_data;
    w_coin_rej_nxt = coin_valid;
    w_cmp4_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (in_RDY4) begin
          w_fee_nxt    = fee_in;
          w_money_nxt  = '0;
          w_timer_nxt  = '0;
          w_refund_nxt = 1'b0;
          w_state_nxt  = (fee_in == '0) ? SEND_RDY : COLLECT;
        end
      end
      COLLECT: begin
        w_coin_rej_nxt = coin_valid && w_sum[MONEY_W];
        if (w_accept) begin
          w_money_nxt = w_sum[MONEY_W-1:0];
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
        // Cancel (or timeout) overrides a covering coin so the refund includes that coin.
        if (cancel || w_timeout) begin
          w_refund_nxt = 1'b1;
          w_state_nxt  = SEND_RDY;
        end else if (w_accept && (w_sum[MONEY_W-1:0] >= r_fee)) begin
          w_state_nxt = SEND_RDY;
        end
      end
      SEND_RDY: begin
        w_out_rdy_nxt = 1'b1;
        w_state_nxt   = SEND_FEE;
      end
      SEND_FEE: begin
        w_data_nxt  = r_refund ? '0 : r_fee;
        w_state_nxt = SEND_MONEY;
      end
      SEND_MONEY: begin
        w_data_nxt  = r_money;
        w_state_nxt = WAIT_CMP;
      end
      WAIT_CMP: begin
        w_data_nxt = '0;
        if (state_cmp5) begin
          w_cmp4_nxt   = 1'b1;
          w_refund_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_data_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fee      <= '0;
      r_money    <= '0;
      r_timer    <= '0;
      r_refund   <= 1'b0;
      r_out_rdy  <= 1'b0;
      r_data     <= '0;
      r_coin_rej <= 1'b0;
      r_busy     <= 1'b0;
      r_cmp4     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fee      <= w_fee_nxt;
      r_money    <= w_money_nxt;
      r_timer    <= w_timer_nxt;
      r_refund   <= w_refund_nxt;
      r_out_rdy  <= w_out_rdy_nxt;
      r_data     <= w_data_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_busy     <= w_busy_nxt;
      r_cmp4     <= w_cmp4_nxt;
    end
  end

  assign out_RDY4   = r_out_rdy;
  assign DATA_out4  = r_data;
  assign coin_rej   = r_coin_rej;
  assign busy       = r_busy;
  assign state_cmp4 = r_cmp4;

endmodule

// File: tb/tb_tf_coin_acc.sv
// Self-checking bench for tf_coin_acc: vector table of transactions plus hand-written corner cases.
module tb_tf_coin_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_RDY4;
  logic [7:0] fee_in;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic       state_cmp5;
  logic       out_RDY4;
  logic [7:0] DATA_out4;
  logic       coin_rej;
  logic       busy;
  logic       state_cmp4;

  tf_coin_acc #(
    .TIMEOUT (8),
    .TW      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_RDY4    (in_RDY4),
    .fee_in     (fee_in),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .cancel     (cancel),
    .state_cmp5 (state_cmp5),
    .out_RDY4   (out_RDY4),
    .DATA_out4  (DATA_out4),
    .coin_rej   (coin_rej),
    .busy       (busy),
    .state_cmp4 (state_cmp4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fee;
    int         ncoins;
    logic [7:0] coins;      // coin i in bits [2i+1:2i]
    bit         cancel_last;
    logic [7:0] exp_fee;
    logic [7:0] exp_money;
    logic [7:0] exp_change; // what the subtractor would produce: fee byte - money byte
  } vec_t;

  typedef struct packed {
    logic [7:0] fee;
    logic [7:0] money;
    logic [7:0] change;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Burst monitor: captures ready/fee/money and compares against the scoreboard.
  initial begin
    int         phase;
    logic [7:0] cap_fee;
    logic [7:0] cap_money;
    exp_t       e;
    phase = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (out_RDY4) phase = 1;
          1: begin
            cap_fee = DATA_out4;
            check("rdy_one_cycle", 32'(out_RDY4), 32'd0);
            phase = 2;
          end
          default: begin
            cap_money = DATA_out4;
            phase = 0;
            if (sb.size() == 0) begin
              check("unexpected_burst", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("burst_fee", 32'(cap_fee), 32'(e.fee));
              check("burst_money", 32'(cap_money), 32'(e.money));
              check("change", 32'(8'(cap_fee - cap_money)), 32'(e.change));
            end
          end
        endcase
      end
    end
  end

  task automatic start(input logic [7:0] f);
    in_RDY4 = 1'b1;
    fee_in  = f;
    tick();
    in_RDY4 = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code, input bit cxl);
    coin_valid = 1'b1;
    coin_code  = code;
    cancel     = cxl;
    tick();
    coin_valid = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic finish_txn();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) begin
      check("burst_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    check("busy_in_wait", 32'(busy), 32'd1);
    state_cmp5 = 1'b1;
    tick();
    state_cmp5 = 1'b0;
    check("cmp4_pulse", 32'(state_cmp4), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    tick();
    check("cmp4_low", 32'(state_cmp4), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    sb.push_back('{fee: v.exp_fee, money: v.exp_money, change: v.exp_change});
    start(v.fee);
    for (int i = 0; i < v.ncoins; i++)
      coin(v.coins[2*i +: 2], v.cancel_last && (i == v.ncoins - 1));
    check("lat_pre", 32'(out_RDY4), 32'd0);
    tick();
    check("lat_rdy", 32'(out_RDY4), 32'd1);
    finish_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0] = '{fee: 8'd15, ncoins: 2, coins: 8'h0B, cancel_last: 0,
                exp_fee: 8'd15, exp_money: 8'd15, exp_change: 8'h00};
    vecs[1] = '{fee: 8'd12, ncoins: 2, coins: 8'h0B, cancel_last: 0,
                exp_fee: 8'd12, exp_money: 8'd15, exp_change: 8'hFD};
    vecs[2] = '{fee: 8'd20, ncoins: 2, coins: 8'h07, cancel_last: 1,
                exp_fee: 8'd0, exp_money: 8'd12, exp_change: 8'hF4};
    vecs[3] = '{fee: 8'd0, ncoins: 0, coins: 8'h00, cancel_last: 0,
                exp_fee: 8'd0, exp_money: 8'd0, exp_change: 8'h00};
    vecs[4] = '{fee: 8'd3, ncoins: 3, coins: 8'h00, cancel_last: 0,
                exp_fee: 8'd3, exp_money: 8'd3, exp_change: 8'h00};
    vecs[5] = '{fee: 8'd7, ncoins: 2, coins: 8'h09, cancel_last: 0,
                exp_fee: 8'd7, exp_money: 8'd7, exp_change: 8'h00};
    vecs[6] = '{fee: 8'd9, ncoins: 2, coins: 8'h0E, cancel_last: 0,
                exp_fee: 8'd9, exp_money: 8'd15, exp_change: 8'hFA};

    rst = 1'b1; in_RDY4 = 1'b0; fee_in = '0; coin_valid = 1'b0;
    coin_code = '0; cancel = 1'b0; state_cmp5 = 1'b0;
    repeat (3) tick();
    check("rst_rdy", 32'(out_RDY4), 32'd0);
    check("rst_data", 32'(DATA_out4), 32'd0);
    check("rst_rej", 32'(coin_rej), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmp4", 32'(state_cmp4), 32'd0);
    rst = 1'b0;
    tick();

    // Coin while idle is returned.
    coin(2'b11, 1'b0);
    check("idle_rej", 32'(coin_rej), 32'd1);
    tick();
    check("idle_rej_low", 32'(coin_rej), 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Overpay with a coin inserted during the burst.
    sb.push_back('{fee: 8'd12, money: 8'd15, change: 8'hFD});
    start(8'd12);
    coin(2'b11, 1'b0);
    coin(2'b10, 1'b0);
    check("collect_busy", 32'(busy), 32'd1);
    coin(2'b11, 1'b0);
    check("burst_rej", 32'(coin_rej), 32'd1);
    finish_txn();

    // Timeout: refund with no further activity after a single 5 coin.
    sb.push_back('{fee: 8'd0, money: 8'd5, change: 8'hFB});
    start(8'd50);
    coin(2'b10, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_RDY4) begin
        lat = i;
        break;
      end
    end
    check("timeout_lat", 32'(lat), 32'd9);
    finish_txn();

    // Saturation: 250 collected, a 10 coin overflows and is returned.
    sb.push_back('{fee: 8'd255, money: 8'd255, change: 8'h00});
    start(8'd255);
    for (int i = 0; i < 25; i++) coin(2'b11, 1'b0);
    check("sat_no_rej", 32'(coin_rej), 32'd0);
    coin(2'b11, 1'b0);
    check("sat_rej", 32'(coin_rej), 32'd1);
    coin(2'b10, 1'b0);
    check("sat_rej_low", 32'(coin_rej), 32'd0);
    finish_txn();

    // Reset while the fee byte is about to be driven.
    start(8'd5);
    coin(2'b10, 1'b0);
    tick();
    check("pre_rst_rdy", 32'(out_RDY4), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_rdy", 32'(out_RDY4), 32'd0);
    check("mid_rst_data", 32'(DATA_out4), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rej", 32'(coin_rej), 32'd0);
    check("mid_rst_cmp4", 32'(state_cmp4), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_txn(vecs[0]);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
